// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit Fibonacci LFSR (x^4+x^3+1) generator/checker pair.
package lfsr_pkg;

  localparam int unsigned LFSR_W      = 4;
  localparam int unsigned TAP_A       = 3;
  localparam int unsigned TAP_B       = 2;
  localparam int unsigned LFSR_PERIOD = 15;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } lfsr_state_t;

  // Next sequence bit from the last LFSR_W bits (index 0 newest): b[n] = b[n-4] ^ b[n-3].
  function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] hist);
    return hist[TAP_A] ^ hist[TAP_B];
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, hold at all-ones, clear on clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 4-bit LFSR test stream: self-synchronises,
// flags mismatching bits and keeps saturating error / checked-bit counters.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = 8,
  parameter int unsigned LOSS_ERRS = 4,
  parameter int unsigned WINDOW    = 15,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned MW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned WBW = $clog2(WINDOW + 1);
  localparam int unsigned WEW = $clog2(LOSS_ERRS + 1);
  localparam int unsigned FW  = $clog2(LFSR_W + 1);

  localparam logic [MW-1:0]  MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WBW-1:0] WIN_LAST   = WBW'(WINDOW - 1);
  localparam logic [WEW-1:0] LOSS_LIM   = WEW'(LOSS_ERRS);
  localparam logic [FW-1:0]  FILL_FULL  = FW'(LFSR_W);

  lfsr_state_t        state;
  logic [LFSR_W-1:0]  hist;
  logic [FW-1:0]      fill;
  logic [MW-1:0]      match_cnt;
  logic [WBW-1:0]     win_bits;
  logic [WEW-1:0]     win_errs;

  logic               pred;
  logic               mismatch;
  logic [WEW-1:0]     errs_now;
  logic               bit_inc;
  logic               err_inc;

  // Prediction, mismatch and window error total including the current bit.
  always_comb begin
    pred     = lfsr_next_bit(hist);
    mismatch = din ^ pred;
    errs_now = win_errs + {{(WEW-1){1'b0}}, mismatch};
    bit_inc  = din_valid && (state == LOCKED);
    err_inc  = bit_inc && mismatch;
  end

  // Acquire/lock state machine with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACQUIRE;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      win_bits  <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      bit_err   <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      bit_err   <= 1'b0;
      lock_lost <= 1'b0;
      if (din_valid) begin
        case (state)
          ACQUIRE: begin
            hist <= {hist[LFSR_W-2:0], din};
            if (fill != FILL_FULL) begin
              fill <= fill + 1'b1;
            end else if (!mismatch && (hist != '0)) begin
              if (match_cnt == MATCH_LAST) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_bits  <= '0;
                win_errs  <= '0;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Feed back the prediction so a single line error costs one error.
            hist    <= {hist[LFSR_W-2:0], pred};
            bit_err <= mismatch;
            if (errs_now == LOSS_LIM) begin
              state     <= ACQUIRE;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              fill      <= '0;
              match_cnt <= '0;
              win_bits  <= '0;
              win_errs  <= '0;
            end else if (win_bits == WIN_LAST) begin
              win_bits <= '0;
              win_errs <= '0;
            end else begin
              win_bits <= win_bits + 1'b1;
              win_errs <= errs_now;
            end
          end
          default: state <= ACQUIRE;
        endcase
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_inc),
    .clr   (clear_cnt),
    .count (err_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bit_inc),
    .clr   (clear_cnt),
    .count (bit_cnt)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker: table-driven lock sequence, scoreboard
// of per-cycle expected outputs from a behavioural model, and corner sequences.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        din, din_valid, clear_cnt;
  logic        locked, bit_err, lock_lost;
  logic [15:0] err_cnt, bit_cnt;

  logic        din4, valid4;
  logic        locked4, bit_err4, lock_lost4;
  logic [3:0]  err_cnt4, bit_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear_cnt(clear_cnt),
    .locked(locked), .bit_err(bit_err), .lock_lost(lock_lost),
    .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  lfsr_checker #(.CNT_W(4), .LOSS_ERRS(16)) dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(valid4), .clear_cnt(1'b0),
    .locked(locked4), .bit_err(bit_err4), .lock_lost(lock_lost4),
    .err_cnt(err_cnt4), .bit_cnt(bit_cnt4)
  );

  typedef struct {
    logic        locked;
    logic        bit_err;
    logic        lock_lost;
    int unsigned err_cnt;
    int unsigned bit_cnt;
  } exp_t;

  typedef struct {
    logic din;
    logic valid;
    logic exp_locked;
  } vec_t;

  exp_t sbq[$];
  logic gseq [15];
  int   gi;

  // Behavioural model state
  logic        m_locked;
  logic [3:0]  m_hist;
  int unsigned m_fill, m_match, m_wb, m_we, m_err, m_bits;
  logic        m_bit_err, m_lock_lost;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_hist = 0; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
    m_err = 0; m_bits = 0; m_bit_err = 0; m_lock_lost = 0;
  endtask

  task automatic model_step(input logic d, input logic v, input logic c);
    logic p;
    m_bit_err = 0;
    m_lock_lost = 0;
    if (!rst) begin
      model_reset();
    end else begin
      if (v) begin
        p = m_hist[3] ^ m_hist[2];
        if (!m_locked) begin
          if (m_fill < 4) m_fill++;
          else if (d == p && m_hist != 4'b0) begin
            m_match++;
            if (m_match == 8) begin
              m_locked = 1; m_match = 0; m_wb = 0; m_we = 0;
            end
          end else m_match = 0;
          m_hist = {m_hist[2:0], d};
        end else begin
          if (m_bits < 65535) m_bits++;
          if (d != p) begin
            m_bit_err = 1;
            if (m_err < 65535) m_err++;
            m_we++;
          end
          m_hist = {m_hist[2:0], p};
          if (m_we >= 4) begin
            m_locked = 0; m_lock_lost = 1; m_fill = 0; m_match = 0; m_wb = 0; m_we = 0;
          end else if (m_wb == 14) begin
            m_wb = 0; m_we = 0;
          end else m_wb++;
        end
      end
      if (c) begin
        m_err = 0; m_bits = 0;
      end
    end
  endtask

  // One clock: drive inputs, push model expectation, compare after the edge.
  task automatic step(input logic d, input logic v, input logic c);
    exp_t e;
    @(negedge clk);
    din = d; din_valid = v; clear_cnt = c;
    model_step(d, v, c);
    e.locked = m_locked; e.bit_err = m_bit_err; e.lock_lost = m_lock_lost;
    e.err_cnt = m_err; e.bit_cnt = m_bits;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sbq.pop_front();
      chk("sb_locked", {31'b0, locked}, {31'b0, e.locked});
      chk("sb_bit_err", {31'b0, bit_err}, {31'b0, e.bit_err});
      chk("sb_lock_lost", {31'b0, lock_lost}, {31'b0, e.lock_lost});
      chk("sb_err_cnt", {16'b0, err_cnt}, e.err_cnt);
      chk("sb_bit_cnt", {16'b0, bit_cnt}, e.bit_cnt);
    end
  endtask

  function automatic logic next_clean();
    logic b;
    b = gseq[gi];
    gi = (gi + 1) % 15;
    return b;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    gi = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [12];
    int   pulses;
    logic never_locked;

    gseq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
             1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    gi = 0;
    din = 0; din_valid = 0; clear_cnt = 0; din4 = 0; valid4 = 0;
    rst = 1'b0;
    model_reset();

    // Reset held with toggling input: everything stays zero.
    for (int i = 0; i < 6; i++) begin
      step(i[0], 1'b1, 1'b0);
      chk("rst_locked", {31'b0, locked}, 0);
      chk("rst_err_cnt", {16'b0, err_cnt}, 0);
    end
    rst = 1'b1;

    // Clean lock from the generator stream: locked rises after the 12th bit.
    for (int i = 0; i < 12; i++) begin
      vt[i].din = gseq[i];
      vt[i].valid = 1'b1;
      vt[i].exp_locked = (i == 11);
    end
    for (int i = 0; i < 12; i++) begin
      step(vt[i].din, vt[i].valid, 1'b0);
      gi++;
      chk("lock_seq", {31'b0, locked}, {31'b0, vt[i].exp_locked});
    end

    // 100 clean locked bits.
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      step(next_clean(), 1'b1, 1'b0);
      if (bit_err) pulses++;
    end
    chk("clean_err_cnt", {16'b0, err_cnt}, 0);
    chk("clean_bit_cnt", {16'b0, bit_cnt}, 100);
    chk("clean_pulses", pulses, 0);

    // Single flipped bit.
    pulses = 0;
    step(~next_clean(), 1'b1, 1'b0);
    if (bit_err) pulses++;
    for (int i = 0; i < 20; i++) begin
      step(next_clean(), 1'b1, 1'b0);
      if (bit_err) pulses++;
    end
    chk("single_pulses", pulses, 1);
    chk("single_err_cnt", {16'b0, err_cnt}, 1);
    chk("single_locked", {31'b0, locked}, 1);

    // Loss of lock: clear counters, align to a window start, flip 4 bits.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && m_wb != 0; i++) step(next_clean(), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(~next_clean(), 1'b1, 1'b0);
      chk("loss_pulse", {31'b0, lock_lost}, (i == 3) ? 1 : 0);
    end
    chk("loss_locked", {31'b0, locked}, 0);
    chk("loss_err_cnt", {16'b0, err_cnt}, 4);
    for (int i = 0; i < 12; i++) begin
      step(next_clean(), 1'b1, 1'b0);
      chk("relock", {31'b0, locked}, (i == 11) ? 1 : 0);
    end

    // Stuck-low then stuck-high line never locks.
    do_reset();
    never_locked = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (locked) never_locked = 1'b0;
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (locked) never_locked = 1'b0;
    end
    chk("stuck_never_locked", {31'b0, never_locked}, 1);

    // Sparse valid: every 3rd cycle, garbage in the gaps.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1'($urandom), 1'b0, 1'b0);
      step(1'($urandom), 1'b0, 1'b0);
      step(next_clean(), 1'b1, 1'b0);
      chk("sparse_lock", {31'b0, locked}, (k == 11) ? 1 : 0);
    end
    step(1'($urandom), 1'b0, 1'b0);
    chk("sparse_gap_hold", {31'b0, locked}, 1);

    // clear_cnt coincident with an error wins over the increment.
    step(~next_clean(), 1'b1, 1'b1);
    chk("clr_err_bit_err", {31'b0, bit_err}, 1);
    chk("clr_err_cnt", {16'b0, err_cnt}, 0);

    // Narrow counters on the second instance: saturate at 15.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      din4 = next_clean(); valid4 = 1'b1;
      step(1'b0, 1'b0, 1'b0);
    end
    chk("sat_locked", {31'b0, locked4}, 1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      din4 = ~next_clean(); valid4 = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      if (bit_err4) pulses++;
      if (lock_lost4) pulses += 100;
    end
    valid4 = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("sat_pulses", pulses, 20);
    chk("sat_err_cnt", {28'b0, err_cnt4}, 15);
    chk("sat_bit_cnt", {28'b0, bit_cnt4}, 15);
    chk("sat_still_locked", {31'b0, locked4}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the team's 4-bit Fibonacci LFSR generator (x^4+x^3+1, period 15).
- Consumes the serial bit stream the generator emits, self-synchronises to it, and flags every bit that departs from the sequence.
- Keeps saturating error and checked-bit counters for link/BIST test.
- Sits at the far end of the serial test path, clocked in the same domain as the sampled data.

Parameters:
- LOCK_CNT, 8, consecutive correct predictions required to declare lock.
- LOSS_ERRS, 4, errors within one window that force loss of lock.
- WINDOW, 15, window length in valid bits for loss-of-lock evaluation.
- CNT_W, 16, width of err_cnt and bit_cnt.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- din  input  1  received serial bit.
- din_valid  input  1  din is sampled on this clock edge.
- clear_cnt  input  1  synchronous clear of err_cnt and bit_cnt.
- locked  output  1  checker synchronised to sequence.
- bit_err  output  1  one-cycle pulse: checked bit mismatched.
- lock_lost  output  1  one-cycle pulse: LOCKED -> ACQUIRE transition.
- err_cnt  output  CNT_W  saturating count of mismatched bits.
- bit_cnt  output  CNT_W  saturating count of bits checked while locked.

Behaviour:
- Reset (rst=0, async):
  - State ACQUIRE; hist=0, fill=0, match_cnt=0, win_bits=0, win_errs=0.
  - All outputs 0.
- Registers:
  - hist[3:0] holds the last 4 bits, hist[0] newest.
  - Prediction pred = hist[3]^hist[2], i.e. b[n] = b[n-4]^b[n-3].
- Holding: nothing changes on cycles with din_valid=0; pulses deassert.
- All outputs are registered. A valid bit sampled at edge k is reflected on outputs after edge k (1-cycle latency).
- ACQUIRE:
  - Each valid bit: hist <= {hist[2:0],din}.
  - While fill<4: fill increments; no comparison.
  - Once fill==4: if din==pred and hist!=0, match_cnt++; else match_cnt=0.
  - The hist!=0 rule rejects all-zero lockup/stuck-low lines.
  - When match_cnt reaches LOCK_CNT: go to LOCKED, locked=1, clear match_cnt/win_bits/win_errs.
  - No bit_err, err_cnt or bit_cnt activity in ACQUIRE.
- LOCKED:
  - Each valid bit: hist <= {hist[2:0],pred}. The predicted bit is fed back, so one line error yields exactly one error.
  - bit_cnt++ on every valid bit.
  - If din!=pred: bit_err=1, err_cnt++, win_errs++.
  - win_bits++. After evaluating the bit at which win_bits==WINDOW-1, clear both win_bits and win_errs.
  - If win_errs (including the current bit) reaches LOSS_ERRS: go to ACQUIRE, locked=0, lock_lost=1, fill=0, match_cnt=0. That bit still raises bit_err and counts.
- Counters: saturate at 2^CNT_W-1 and never wrap.
- clear_cnt: zeroes err_cnt and bit_cnt next edge and wins over a coincident increment. Does not affect state, hist or window.
- Reset mid-operation: immediate return to the reset values above, regardless of state.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_W=4.
  - Tap indices TAP_A=3, TAP_B=2.
  - LFSR_PERIOD=15.
  - State enum {ACQUIRE, LOCKED}.
  - Also used by the generator.
- One sub-module: sat_counter (width parameter, inc, clr with priority, saturating), instantiated for err_cnt and bit_cnt.

Test Plan:
- Reset: hold rst=0 with din toggling -> locked=0, bit_err=0, lock_lost=0, err_cnt=0, bit_cnt=0 throughout. Release -> still 0 until lock.
- Clean lock: drive generator (seed 0001) stream 0,0,1,1,0,1,0,1,1,1,1,0,0,0,1 repeating, din_valid=1 every cycle -> locked rises on the edge after the 12th bit. Then 100 more bits -> err_cnt=0, bit_cnt=100, no bit_err.
- Single error: flip one bit after lock -> exactly one bit_err pulse, err_cnt=1, locked stays 1, subsequent bits clean.
- Lock loss: flip 4 bits within 15 valid bits -> lock_lost pulse on the 4th, locked=0, err_cnt=4. Resume clean stream -> relock after 12 valid bits.
- Stuck line: 40 valid bits of din=0 -> locked never asserts. 40 bits of din=1 (mismatches) -> never locks.
- Edges: din_valid every 3rd cycle -> locks after 12 valid bits, state frozen in gaps. clear_cnt coincident with an error -> err_cnt=0. CNT_W=4 with 20 errors while held locked (LOSS_ERRS=16) -> err_cnt=15.
